// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and branch-operand stalls, jump/taken-branch
// flushes, plus saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             branch_taken,
  input  logic             ex_memRead,
  input  logic             ex_regWrite,
  input  logic [4:0]       ex_rd,
  input  logic             mem_memRead,
  input  logic [4:0]       mem_rd,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             ctrl_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {StRun, StLdbr} state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e state_q;
  logic   ex_match, mem_match;
  logic   lu_haz, br_alu, br_ld_ex, br_ld_mem;
  logic   stall;

  // Register 0 is hardwired zero, so it never creates a dependency.
  function automatic logic match(input logic [4:0] r, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  always_comb begin
    ex_match  = match(ex_rd, id_rs, id_rt, id_uses_rt);
    mem_match = match(mem_rd, id_rs, id_rt, id_uses_rt);
    lu_haz    = ex_memRead && ex_match;
    br_alu    = id_branch && ex_regWrite && !ex_memRead && ex_match;
    br_ld_ex  = id_branch && ex_memRead && ex_match;
    br_ld_mem = id_branch && mem_memRead && mem_match;
    // Reset forces the non-stall, non-flush output pattern regardless of inputs.
    stall      = rst_n && ((state_q == StLdbr) || lu_haz || br_alu || br_ld_ex || br_ld_mem);
    pc_write   = !stall;
    ifid_write = !stall;
    ctrl_flush = stall;
    ifid_flush = rst_n && !stall && (id_jump || (id_branch && branch_taken));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (state_q)
        StRun:   if (br_ld_ex) state_q <= StLdbr;
        StLdbr:  state_q <= StRun;
        default: state_q <= StRun;
      endcase
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CntOne;
      if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CntOne;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus queues expected outputs per cycle, a
// negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic        id_uses_rt, id_branch, id_jump, branch_taken;
  logic        ex_memRead, ex_regWrite, mem_memRead;
  logic        pc_write, ifid_write, ifid_flush, ctrl_flush;
  logic [15:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_jump(id_jump), .branch_taken(branch_taken),
    .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite), .ex_rd(ex_rd),
    .mem_memRead(mem_memRead), .mem_rd(mem_rd),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .ctrl_flush(ctrl_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    string       name;
    logic [3:0]  outs;  // {pc_write, ifid_write, ifid_flush, ctrl_flush}
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_sc = 16'd0;
  logic [15:0] m_fc = 16'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one expected entry per stimulus cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if ({pc_write, ifid_write, ifid_flush, ctrl_flush} !== e.outs) begin
        n_fail++;
        $display("FAIL %s outs: got pc/ifid_w/ifid_fl/ctrl_fl=%b expected %b", e.name,
                 {pc_write, ifid_write, ifid_flush, ctrl_flush}, e.outs);
      end
      n_checks++;
      if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        n_fail++;
        $display("FAIL %s counters: got stall=%h flush=%h expected stall=%h flush=%h",
                 e.name, stall_cnt, flush_cnt, e.sc, e.fc);
      end
    end
  end

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    id_branch = 1'b0; id_jump = 1'b0; branch_taken = 1'b0;
    ex_memRead = 1'b0; ex_regWrite = 1'b0; ex_rd = 5'd0;
    mem_memRead = 1'b0; mem_rd = 5'd0;
  endtask

  // Inputs are already driven; queue the expected response for this cycle and
  // advance the counter model by what the upcoming edge should record.
  task automatic step(input string name, input bit s, input bit f, input bit chk = 1'b1);
    exp_t e;
    if (!rst_n) begin
      m_sc = 16'd0;
      m_fc = 16'd0;
    end
    if (chk) begin
      e.name = name;
      e.outs = {!s, !s, f, s};
      e.sc   = m_sc;
      e.fc   = m_fc;
      sb.push_back(e);
    end
    if (rst_n) begin
      if (s && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (f && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    // Hazard inputs present while in reset must not stall.
    ex_memRead = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    step("reset_with_hazard", 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(); step("idle_after_reset", 1'b0, 1'b0);

    // Load-use on rs.
    ex_memRead = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    step("load_use_rs", 1'b1, 1'b0);
    idle(); step("after_load_use", 1'b0, 1'b0);

    // Branch after load: EX detect then LDBR cycle with nothing else pending.
    id_branch = 1'b1; ex_memRead = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    step("br_ld_ex", 1'b1, 1'b0);
    idle(); id_branch = 1'b1; id_rt = 5'd9; id_uses_rt = 1'b1;
    step("ldbr_state", 1'b1, 1'b0);
    step("after_ldbr", 1'b0, 1'b0);

    // Branch after load where the load has reached MEM as well.
    idle(); id_branch = 1'b1; id_rs = 5'd12; ex_memRead = 1'b1; ex_rd = 5'd12;
    step("br_ld_ex_2", 1'b1, 1'b0);
    idle(); id_branch = 1'b1; id_rs = 5'd12; mem_memRead = 1'b1; mem_rd = 5'd12;
    step("ldbr_with_mem", 1'b1, 1'b0);
    idle(); id_branch = 1'b1; id_rs = 5'd12; branch_taken = 1'b1;
    step("branch_resolved_taken", 1'b0, 1'b1);

    // Branch after ALU: single stall, then taken branch flushes.
    idle(); id_branch = 1'b1; ex_regWrite = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; branch_taken = 1'b1;
    step("br_alu", 1'b1, 1'b0);
    idle(); id_branch = 1'b1; id_rs = 5'd3; branch_taken = 1'b1;
    step("br_alu_resolved", 1'b0, 1'b1);

    // Plain flushes and stall-over-flush priority.
    idle(); id_branch = 1'b1; branch_taken = 1'b1; id_rs = 5'd7;
    step("taken_branch", 1'b0, 1'b1);
    idle(); id_branch = 1'b1; branch_taken = 1'b0; id_rs = 5'd7;
    step("not_taken_branch", 1'b0, 1'b0);
    idle(); id_jump = 1'b1;
    step("jump", 1'b0, 1'b1);
    idle(); id_jump = 1'b1; ex_memRead = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
    step("jump_with_lu", 1'b1, 1'b0);
    idle(); id_branch = 1'b1; branch_taken = 1'b1; ex_memRead = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
    step("taken_br_with_lu", 1'b1, 1'b0);
    idle(); id_branch = 1'b1; branch_taken = 1'b1; id_rs = 5'd4;
    step("taken_br_in_ldbr", 1'b1, 1'b0);

    // Register 0 and unused rt never stall.
    idle(); ex_memRead = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    step("r0_no_stall", 1'b0, 1'b0);
    idle(); ex_memRead = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_rs = 5'd1; id_uses_rt = 1'b0;
    step("rt_unused", 1'b0, 1'b0);
    id_uses_rt = 1'b1;
    step("rt_used", 1'b1, 1'b0);
    idle(); mem_memRead = 1'b1; mem_rd = 5'd6; id_rs = 5'd6;
    step("mem_load_non_branch", 1'b0, 1'b0);
    idle(); id_branch = 1'b1; mem_memRead = 1'b1; mem_rd = 5'd0; ex_regWrite = 1'b1; ex_rd = 5'd0;
    step("branch_r0", 1'b0, 1'b0);

    // Reset pulse during LDBR abandons the stall immediately.
    idle(); id_branch = 1'b1; ex_memRead = 1'b1; ex_rd = 5'd10; id_rs = 5'd10;
    step("ldbr_enter", 1'b1, 1'b0);
    idle(); id_branch = 1'b1; rst_n = 1'b0;
    step("reset_in_ldbr", 1'b0, 1'b0);
    rst_n = 1'b1;
    step("run_after_reset", 1'b0, 1'b0);

    // Saturation: drive continuous load-use until the stall counter tops out.
    idle(); ex_memRead = 1'b1; ex_rd = 5'd2; id_rs = 5'd2;
    for (int i = 0; i < 65534 - int'(m_sc); i++) step("sat_fill", 1'b1, 1'b0, 1'b0);
    step("sat_fffe", 1'b1, 1'b0);
    step("sat_ffff", 1'b1, 1'b0);
    step("sat_hold_1", 1'b1, 1'b0);
    idle(); step("sat_hold_2", 1'b0, 1'b0);

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
